// File: rtl/rv_shift_pkg.sv
// Shared definitions for the RV32 iterative shift unit: op codes, FSM encoding and width helpers.
package rv_shift_pkg;

  localparam int unsigned DEFAULT_XLEN = 32;
  localparam int unsigned XLEN_LOG2    = $clog2(DEFAULT_XLEN);

  localparam logic [1:0] SHOP_SLL = 2'b00;
  localparam logic [1:0] SHOP_SRL = 2'b01;
  localparam logic [1:0] SHOP_SRA = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves XLEN bits by 0..STEP_MAX positions.
module shift_step #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned STEP_MAX = 8,
  localparam int unsigned AmtW    = $clog2(STEP_MAX) + 1
) (
  input  logic [XLEN-1:0] data,
  input  logic [AmtW-1:0] amt,
  input  logic            right,
  input  logic            fill,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] fill_mask;

  always_comb begin
    // Ones in the vacated upper positions of a right shift.
    fill_mask = ~({XLEN{1'b1}} >> amt);
    if (right) begin
      result = (data >> amt) | (fill ? fill_mask : '0);
    end else begin
      result = data << amt;
    end
  end

endmodule

// File: rtl/shift_seq_unit.sv
// RV32 execute-stage shift unit: SLL/SRL/SRA performed iteratively, up to STEP_MAX bits per cycle.
module shift_seq_unit
  import rv_shift_pkg::*;
#(
  parameter int unsigned XLEN     = DEFAULT_XLEN,
  parameter int unsigned STEP_MAX = 8,
  parameter int unsigned TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_data,
  input  logic [XLEN-1:0]  in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned ShW  = $clog2(XLEN);
  localparam int unsigned AmtW = $clog2(STEP_MAX) + 1;

  shift_state_e     state_q, state_d;
  logic [XLEN-1:0]  work_q, work_d;
  logic [XLEN-1:0]  out_data_q, out_data_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [ShW-1:0]   remaining_q, remaining_d;
  logic             right_q, right_d;
  logic             fill_q, fill_d;

  logic [AmtW-1:0]  step;
  logic [XLEN-1:0]  step_result;
  logic [ShW-1:0]   sh;
  logic             unused_shamt_hi;

  // RV32 rule: only the low log2(XLEN) bits of the shift amount matter.
  assign sh              = in_shamt[ShW-1:0];
  assign unused_shamt_hi = ^in_shamt[XLEN-1:ShW];

  always_comb begin
    if (32'(remaining_q) >= STEP_MAX) begin
      step = AmtW'(STEP_MAX);
    end else begin
      step = AmtW'(remaining_q);
    end
  end

  shift_step #(
    .XLEN     (XLEN),
    .STEP_MAX (STEP_MAX)
  ) u_shift_step (
    .data   (work_q),
    .amt    (step),
    .right  (right_q),
    .fill   (fill_q),
    .result (step_result)
  );

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    out_data_d  = out_data_q;
    tag_d       = tag_q;
    out_tag_d   = out_tag_q;
    remaining_d = remaining_q;
    right_d     = right_q;
    fill_d      = fill_q;

    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            work_d  = in_data;
            tag_d   = in_tag;
            right_d = in_op[0];
            fill_d  = (in_op == SHOP_SRA) & in_data[XLEN-1];
            if (sh == '0) begin
              state_d    = StDone;
              out_data_d = in_data;
              out_tag_d  = in_tag;
            end else begin
              state_d     = StShift;
              remaining_d = sh;
            end
          end
        end
        StShift: begin
          work_d      = step_result;
          remaining_d = remaining_q - ShW'(step);
          if (remaining_d == '0) begin
            state_d    = StDone;
            out_data_d = step_result;
            out_tag_d  = tag_q;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      work_q      <= '0;
      out_data_q  <= '0;
      tag_q       <= '0;
      out_tag_q   <= '0;
      remaining_q <= '0;
      right_q     <= 1'b0;
      fill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      out_data_q  <= out_data_d;
      tag_q       <= tag_d;
      out_tag_q   <= out_tag_d;
      remaining_q <= remaining_d;
      right_q     <= right_d;
      fill_q      <= fill_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && rst_n;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed bench for shift_seq_unit: latency, fill rules, backpressure, flush and reset recovery.
module tb_shift_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_data;
  logic [31:0] in_shamt;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_seq_unit #(
    .XLEN     (32),
    .STEP_MAX (8),
    .TAG_W    (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                            input logic [31:0] shamt);
    logic [4:0] s;
    s = shamt[4:0];
    case (op)
      2'b01:   ref_shift = d >> s;
      2'b11:   ref_shift = 32'($signed(d) >>> s);
      default: ref_shift = d << s;
    endcase
  endfunction

  // Presents one request for a single edge; caller is at #1 after an edge with in_ready high.
  task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [31:0] s,
                      input logic [4:0] t);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = s;
    in_tag   = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op    = 2'b10;
    in_data  = 32'h1234_5678;
    in_shamt = 32'h0;
    in_tag   = 5'h1f;
  endtask

  // Cycle index (1 = right after the accept edge) of first out_valid; bounded.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, busy, in_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got v/b/r=%b required 000", {out_valid, busy, in_ready});
    end
    n_checks++;
    if (out_data !== 32'h0 || out_tag !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h required 0/0", out_data, out_tag);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sll31;
    int cyc;
    send(2'b00, 32'h0000_0001, 32'd31, 5'd7);
    wait_valid(cyc);
    n_checks++;
    if (cyc !== 5 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL sll31_latency: got %0d (valid %b) required 5", cyc, out_valid);
    end
    n_checks++;
    if (out_data !== 32'h8000_0000 || out_tag !== 5'd7) begin
      n_fail++;
      $display("FAIL sll31_result: got %h/%0d required 80000000/7", out_data, out_tag);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sll31_handshake: got busy %b valid %b required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_sra_srl;
    int cyc;
    send(2'b11, 32'h8000_00F0, 32'd4, 5'd3);
    wait_valid(cyc);
    n_checks++;
    if (cyc !== 2 || out_data !== 32'hF800_000F) begin
      n_fail++;
      $display("FAIL sra4: got %h after %0d required f800000f after 2", out_data, cyc);
    end
    @(posedge clk); #1;
    send(2'b01, 32'h8000_00F0, 32'd4, 5'd4);
    wait_valid(cyc);
    n_checks++;
    if (cyc !== 2 || out_data !== 32'h0800_000F || out_tag !== 5'd4) begin
      n_fail++;
      $display("FAIL srl4: got %h/%0d after %0d required 0800000f/4 after 2", out_data, out_tag, cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_shift;
    int cyc;
    logic [31:0] amts [2];
    amts[0] = 32'd0;
    amts[1] = 32'd32;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      send(2'b00, 32'hDEAD_BEEF, amts[i], 5'(i + 10));
      wait_valid(cyc);
      n_checks++;
      if (cyc !== 1 || out_data !== 32'hDEAD_BEEF || out_tag !== 5'(i + 10)) begin
        n_fail++;
        $display("FAIL zero_shift[%0d]: got %h/%0d after %0d required deadbeef/%0d after 1",
                 i, out_data, out_tag, cyc, i + 10);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_shift_ready[%0d]: got %b required 0", i, in_ready);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_backpressure;
    int cyc;
    int bad = 0;
    out_ready = 1'b0;
    send(2'b01, 32'hF000_0000, 32'd12, 5'd21);
    wait_valid(cyc);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_op    = 2'b00;
      in_data  = 32'hFFFF_FFFF;
      in_shamt = 32'd0;
      in_tag   = 5'd2;
      if (out_valid !== 1'b1 || out_data !== 32'h000F_0000 || out_tag !== 5'd21 ||
          in_ready !== 1'b0) begin
        bad++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: %0d unstable cycles required 0 (last %h/%0d)",
               bad, out_data, out_tag);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: got valid %b busy %b required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_flush;
    int cyc;
    int seen = 0;
    send(2'b00, 32'h0000_0001, 32'd20, 5'd9);
    @(posedge clk); #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_shift: got busy %b ready %b required 0 1", busy, in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL flush_no_valid: got %0d valid cycles required 0", seen);
    end
    // Flush in idle must win over a pending request.
    flush    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_accept: got busy %b required 0", busy);
    end
    send(2'b01, 32'h0000_00F0, 32'd4, 5'd5);
    wait_valid(cyc);
    n_checks++;
    if (out_data !== 32'h0000_000F || out_tag !== 5'd5 || cyc !== 2) begin
      n_fail++;
      $display("FAIL flush_next_op: got %h/%0d after %0d required 0000000f/5 after 2",
               out_data, out_tag, cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    send(2'b11, 32'h8000_0000, 32'd31, 5'd17);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, busy, in_ready} !== 3'b000 || out_data !== 32'h0 || out_tag !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got v/b/r=%b data %h tag %0d required 000/0/0",
               {out_valid, busy, in_ready}, out_data, out_tag);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [1:0]  op;
    logic [31:0] d;
    logic [31:0] s;
    logic [31:0] exp_d;
    int exp_lat;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      d  = $urandom;
      s  = $urandom | 32'h0000_0020;
      exp_d   = ref_shift(op, d, s);
      exp_lat = (int'(s[4:0]) + 7) / 8 + 1;
      send(op, d, s, 5'(i + 1));
      wait_valid(cyc);
      n_checks++;
      if (out_data !== exp_d || out_tag !== 5'(i + 1) || cyc !== exp_lat) begin
        n_fail++;
        $display("FAIL b2b[%0d] op %b d %h s %h: got %h/%0d lat %0d required %h/%0d lat %0d",
                 i, op, d, s, out_data, out_tag, cyc, exp_d, i + 1, exp_lat);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_data   = 32'h0;
    in_shamt  = 32'h0;
    in_tag    = 5'h0;
    out_ready = 1'b1;
    test_reset();
    test_sll31();
    test_sra_srl();
    test_zero_shift();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
